// File: rtl/wb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_regfile
// Purpose  : Wishbone slave exposing NUM_REGS read/write registers with
//            byte-lane selects, a programmable number of wait states and
//            either classic or pipelined handshaking.
//
// Ports    : clk_i    in   clock
//            rst_i    in   synchronous active-high reset
//            adr_i    in   word address            [ADDR_WIDTH-1:0]
//            dat_i    in   write data              [DATA_WIDTH-1:0]
//            dat_o    out  read data               [DATA_WIDTH-1:0]
//            sel_i    in   byte-lane select        [SEL_WIDTH-1:0]
//            we_i     in   write enable
//            cyc_i    in   bus cycle
//            stb_i    in   strobe
//            ack_o    out  acknowledge (one-cycle pulse)
//            err_o    out  error (one-cycle pulse)
//            stall_o  out  stall (pipelined mode only)
//
// Macro    : WB_SLAVE_REGFILE_ERR_EN -- when defined, an out-of-range
//            address or an all-zero sel_i ends in err_o instead of ack_o.
//
// Revision : 1.0  initial release
// ============================================================================
module wb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    GRANULE     = 8,
  parameter int                    NUM_REGS    = 4,
  parameter int unsigned           BASE_ADDR   = 0,
  parameter int                    WAIT_STATES = 0,
  parameter int                    PIPELINED   = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   SEL_WIDTH   = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  we_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Range bounds carry one extra bit so BASE_ADDR+NUM_REGS cannot wrap.
  localparam logic [ADDR_WIDTH:0] LO_ADDR = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] HI_ADDR = (ADDR_WIDTH+1)'(BASE_ADDR + NUM_REGS);
  localparam logic [3:0]          WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Request captured at acceptance; the bus may change freely afterwards.
  logic [IDX_W-1:0]      idx_q;
  logic                  hit_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0]  sel_q;

  logic                  ack_q, err_q;
  logic [ADDR_WIDTH:0]   adr_ext;
  logic                  in_range;
  logic                  can_accept, accept;
  logic                  resp, resp_ok;
  logic [DATA_WIDTH-1:0] lane_mask, rd_word;

  assign adr_ext  = {1'b0, adr_i};
  assign in_range = (adr_ext >= LO_ADDR) && (adr_ext < HI_ADDR);

  generate
    if (PIPELINED != 0) begin : g_pipe
      assign stall_o    = (state == ST_WAIT);
      assign can_accept = (state == ST_IDLE) || (state == ST_RESP);
    end else begin : g_classic
      // The strobe is still high during the ack cycle; holding off until
      // the pulse clears keeps that strobe from starting a second transfer.
      assign stall_o    = 1'b0;
      assign can_accept = (state == ST_IDLE) && !ack_q && !err_q;
    end
  endgenerate

  assign accept = cyc_i && stb_i && !stall_o && can_accept;
  assign resp   = (state == ST_RESP);

`ifdef WB_SLAVE_REGFILE_ERR_EN
  assign resp_ok = hit_q && (sel_q != '0);
`else
  assign resp_ok = 1'b1;
`endif

  generate
    for (genvar k = 0; k < SEL_WIDTH; k++) begin : g_lane
      assign lane_mask[k*GRANULE +: GRANULE] = {GRANULE{sel_q[k]}};
    end
  endgenerate

  // Index compare instead of direct array indexing so an index that
  // overshoots a non-power-of-two NUM_REGS simply reads zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rd_word = regs[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: ;
      ST_WAIT: begin
        if (!cyc_i) begin
          state_nxt = ST_IDLE;      // master abandoned the cycle
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      cnt_nxt   = WS_LOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      hit_q <= 1'b0;
      we_q  <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (accept) begin
      idx_q <= IDX_W'(adr_i - LO_ADDR[ADDR_WIDTH-1:0]);
      hit_q <= in_range;
      we_q  <= we_i;
      dat_q <= dat_i;
      sel_q <= sel_i;
    end
  end

  // --------------------------------------------------------------------------
  // Response: the edge leaving RESP raises ack/err, commits the write and
  // captures read data together.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_q <= resp && resp_ok;
      err_q <= resp && !resp_ok;
      if (resp) begin
        dat_o <= (!we_q && hit_q && resp_ok) ? (rd_word & lane_mask) : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (resp && we_q && hit_q && resp_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          regs[i] <= (regs[i] & ~lane_mask) | (dat_q & lane_mask);
        end
      end
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_slave_regfile
// Purpose  : Directed self-checking bench for wb_slave_regfile. Four DUTs:
//            0 classic/0 wait, 1 classic/3 wait, 2 pipelined/0 wait,
//            3 classic/2 wait. Honours WB_SLAVE_REGFILE_ERR_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_slave_regfile;

`ifdef WB_SLAVE_REGFILE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk, rst;
  logic [3:0]       cyc, stb, we;
  logic [3:0][15:0] adr;
  logic [3:0][31:0] dw;
  logic [3:0][3:0]  sel;
  wire  [3:0][31:0] dr;
  wire  [3:0]       ack, err, stall;

  int          total, bad;
  logic [31:0] rd;
  logic        ak, er;
  int          lat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wb_slave_regfile #(.WAIT_STATES(0), .PIPELINED(0), .RESET_VALUE(32'h0000_0000)) u_c0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[0]), .dat_i(dw[0]), .dat_o(dr[0]), .sel_i(sel[0]),
    .we_i(we[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .ack_o(ack[0]), .err_o(err[0]), .stall_o(stall[0]));

  wb_slave_regfile #(.WAIT_STATES(3), .PIPELINED(0), .RESET_VALUE(32'hA5A5_5A5A)) u_c3 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[1]), .dat_i(dw[1]), .dat_o(dr[1]), .sel_i(sel[1]),
    .we_i(we[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .ack_o(ack[1]), .err_o(err[1]), .stall_o(stall[1]));

  wb_slave_regfile #(.WAIT_STATES(0), .PIPELINED(1), .RESET_VALUE(32'h0000_0000)) u_p0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[2]), .dat_i(dw[2]), .dat_o(dr[2]), .sel_i(sel[2]),
    .we_i(we[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .ack_o(ack[2]), .err_o(err[2]), .stall_o(stall[2]));

  wb_slave_regfile #(.WAIT_STATES(2), .PIPELINED(0), .RESET_VALUE(32'h0000_1111)) u_c2 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[3]), .dat_i(dw[3]), .dat_o(dr[3]), .sel_i(sel[3]),
    .we_i(we[3]), .cyc_i(cyc[3]), .stb_i(stb[3]), .ack_o(ack[3]), .err_o(err[3]), .stall_o(stall[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Classic single transfer on DUT u. Called 1 time unit after a rising
  // edge; scrambles the bus right after acceptance, holds the strobe until
  // the response, then idles one cycle and confirms the pulse was single.
  task automatic xfer(input int u, input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdata, output logic ok_ack,
                      output logic ok_err, output int n);
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; adr[u] = a; dw[u] = d; sel[u] = s;
    @(posedge clk); #1;
    we[u] = ~w; adr[u] = ~a; dw[u] = ~d; sel[u] = ~s;
    n = 0;
    while (!(ack[u] || err[u]) && n < 32) begin
      @(posedge clk); #1;
      n++;
    end
    rdata = dr[u]; ok_ack = ack[u]; ok_err = err[u];
    cyc[u] = 1'b0; stb[u] = 1'b0;
    @(posedge clk); #1;
    check("resp_single_pulse", {30'd0, ack[u], err[u]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; cyc = '0; stb = '0; we = '0; adr = '0; dw = '0; sel = '0;
    // Strobe asserted throughout reset must not be accepted.
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 16'd2; sel[0] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack[0]}, 32'd0);
    check("rst_err", {31'd0, err[0]}, 32'd0);
    check("rst_dat", dr[0], 32'd0);
    check("rst_stall_pipe", {31'd0, stall[2]}, 32'd0);
    rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_no_resp", {30'd0, ack[0], err[0]}, 32'd0);
    end

    // Basic write / read, zero wait states
    xfer(0, 1'b1, 16'd2, 32'hDEAD_BEEF, 4'hF, rd, ak, er, lat);
    check("wr_ack", {31'd0, ak}, 32'd1);
    check("wr_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 16'd2, 32'h0, 4'hF, rd, ak, er, lat);
    check("rd_ack", {31'd0, ak}, 32'd1);
    check("rd_lat", 32'(lat), 32'd1);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_hold", dr[0], 32'hDEAD_BEEF);

    // Byte lanes
    xfer(0, 1'b1, 16'd3, 32'h1122_3344, 4'hF, rd, ak, er, lat);
    xfer(0, 1'b1, 16'd3, 32'hAABB_CCDD, 4'h5, rd, ak, er, lat);
    xfer(0, 1'b0, 16'd3, 32'h0, 4'hF, rd, ak, er, lat);
    check("lane_rd_all", rd, 32'h11BB_33DD);
    xfer(0, 1'b0, 16'd3, 32'h0, 4'h3, rd, ak, er, lat);
    check("lane_rd_sel3", rd, 32'h0000_33DD);

    // Out-of-range and empty-select transfers
    xfer(0, 1'b1, 16'd6, 32'hCAFE_F00D, 4'hF, rd, ak, er, lat);
    check("oor_wr_ack", {31'd0, ak}, {31'd0, ~ERR_EN});
    check("oor_wr_err", {31'd0, er}, {31'd0, ERR_EN});
    xfer(0, 1'b0, 16'd2, 32'h0, 4'hF, rd, ak, er, lat);
    check("oor_no_alias", rd, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 16'd4, 32'h0, 4'hF, rd, ak, er, lat);
    check("oor_rd_ack", {31'd0, ak}, {31'd0, ~ERR_EN});
    check("oor_rd_err", {31'd0, er}, {31'd0, ERR_EN});
    check("oor_rd_data", rd, 32'd0);
    xfer(0, 1'b0, 16'hFFFF, 32'h0, 4'hF, rd, ak, er, lat);
    check("oor_top_data", rd, 32'd0);
    xfer(0, 1'b1, 16'd1, 32'hFFFF_FFFF, 4'h0, rd, ak, er, lat);
    check("sel0_ack", {31'd0, ak}, {31'd0, ~ERR_EN});
    check("sel0_err", {31'd0, er}, {31'd0, ERR_EN});
    xfer(0, 1'b0, 16'd1, 32'h0, 4'hF, rd, ak, er, lat);
    check("sel0_unchanged", rd, 32'd0);

    // Pipelined back-to-back: write r1=5, read r1, read r0
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 16'd1; dw[2] = 32'h5; sel[2] = 4'hF;
    @(posedge clk); #1;
    check("p_stall0", {31'd0, stall[2]}, 32'd0);
    check("p_ack0", {31'd0, ack[2]}, 32'd0);
    we[2] = 1'b0; adr[2] = 16'd1; dw[2] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("p_ack1", {31'd0, ack[2]}, 32'd1);
    check("p_stall1", {31'd0, stall[2]}, 32'd0);
    adr[2] = 16'd0;
    @(posedge clk); #1;
    check("p_ack2", {31'd0, ack[2]}, 32'd1);
    check("p_rd_r1", dr[2], 32'h5);
    check("p_stall2", {31'd0, stall[2]}, 32'd0);
    stb[2] = 1'b0; adr[2] = 16'h00FF;
    @(posedge clk); #1;
    check("p_ack3", {31'd0, ack[2]}, 32'd1);
    check("p_rd_r0", dr[2], 32'h0);
    cyc[2] = 1'b0;
    @(posedge clk); #1;
    check("p_idle", {31'd0, ack[2]}, 32'd0);

    // Three wait states
    xfer(1, 1'b0, 16'd0, 32'h0, 4'hF, rd, ak, er, lat);
    check("ws3_ack", {31'd0, ak}, 32'd1);
    check("ws3_lat", 32'(lat), 32'd4);
    check("ws3_data", rd, 32'hA5A5_5A5A);

    // Abort: cyc dropped while waiting
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; adr[3] = 16'd1; dw[3] = 32'h77; sel[3] = 4'hF;
    @(posedge clk); #1;
    cyc[3] = 1'b0; stb[3] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("abort_no_resp", {30'd0, ack[3], err[3]}, 32'd0);
    end
    xfer(3, 1'b0, 16'd1, 32'h0, 4'hF, rd, ak, er, lat);
    check("abort_lat", 32'(lat), 32'd3);
    check("abort_unchanged", rd, 32'h0000_1111);
    xfer(3, 1'b1, 16'd1, 32'h99, 4'hF, rd, ak, er, lat);
    xfer(3, 1'b0, 16'd1, 32'h0, 4'hF, rd, ak, er, lat);
    check("ws2_rd_back", rd, 32'h99);

    // Reset pulsed mid-wait
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; adr[3] = 16'd2; dw[3] = 32'h3333; sel[3] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc[3] = 1'b0; stb[3] = 1'b0;
    check("mid_rst_dat", dr[3], 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("mid_rst_no_resp", {30'd0, ack[3], err[3]}, 32'd0);
    end
    xfer(3, 1'b0, 16'd1, 32'h0, 4'hF, rd, ak, er, lat);
    check("mid_rst_r1", rd, 32'h0000_1111);
    xfer(3, 1'b0, 16'd2, 32'h0, 4'hF, rd, ak, er, lat);
    check("mid_rst_r2", rd, 32'h0000_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
